hardreg_arb: RTL and testbench

HARDREG_ARB -- requirements
Module: hardreg_arb

---
 rtl/hardreg_arb_pkg.sv | 18 +
 rtl/hardreg.sv | 16 +
 rtl/hardreg_arb.sv | 99 +++++++++
 tb/tb_hardreg_arb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hardreg_arb_pkg.sv
// Shared types and constants for the two-requester shared-register arbiter.
package hardreg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    // Saturating increment for the write counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hardreg.sv
// Shared storage register with asynchronous active-low clear.
module hardreg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             clrb,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/hardreg_arb.sv
// Round-robin arbiter granting two requesters write access to one shared
// register, with a synchronous clear request and a saturating write counter.
module hardreg_arb
    import hardreg_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             clr_req,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] qout,
    output logic             busy,
    output logic [CNT_W-1:0] wr_cnt
);

    state_t             state;
    state_t             state_next;
    logic               ptr;
    logic               ptr_next;
    logic               pick1;
    logic [WIDTH-1:0]   wr_reg;
    logic [WIDTH-1:0]   wr_next;
    logic [WIDTH-1:0]   reg_d;
    logic [CNT_W-1:0]   cnt_next;
    logic               gnt0_next;
    logic               gnt1_next;
    logic               busy_next;
    logic               clrb;

    // Next-state, arbitration and write-capture decisions.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        wr_next    = wr_reg;
        cnt_next   = wr_cnt;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        pick1      = req1 & (~req0 | ptr);
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else if (req0 | req1) begin
                    state_next = LOAD;
                    gnt0_next  = ~pick1;
                    gnt1_next  = pick1;
                    wr_next    = pick1 ? data1 : data0;
                    ptr_next   = ~pick1;
                    cnt_next   = sat_inc(wr_cnt);
                end
            end
            LOAD:    state_next = IDLE;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            wr_reg <= '0;
            wr_cnt <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            wr_reg <= wr_next;
            wr_cnt <= cnt_next;
            gnt0   <= gnt0_next;
            gnt1   <= gnt1_next;
            busy   <= busy_next;
        end
    end

    // Register recirculates outside LOAD; clr aborts any in-flight write.
    assign reg_d = (state == LOAD) ? wr_reg : qout;
    assign clrb  = ~(clr | (state == CLEAR));

    hardreg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .d    (reg_d),
        .clk  (clk),
        .clrb (clrb),
        .q    (qout)
    );

endmodule

// File: tb/tb_hardreg_arb.sv
// Self-checking bench for hardreg_arb: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_hardreg_arb;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             clr;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             clr_req;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] qout;
    logic             busy;
    logic [7:0]       wr_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: one pending write, a busy flag and a favoured requester.
    logic             m_busy;
    logic             m_pend_valid;
    logic [WIDTH-1:0] m_pend;
    logic [WIDTH-1:0] m_q;
    int               m_cnt;
    int               m_fav;
    logic             m_g0;
    logic             m_g1;

    hardreg_arb #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .clr_req (clr_req),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .qout    (qout),
        .busy    (busy),
        .wr_cnt  (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy       = 1'b0;
        m_pend_valid = 1'b0;
        m_pend       = '0;
        m_q          = '0;
        m_cnt        = 0;
        m_fav        = 0;
        m_g0         = 1'b0;
        m_g1         = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (m_busy) begin
            if (m_pend_valid) m_q = m_pend;
            m_pend_valid = 1'b0;
            m_busy       = 1'b0;
        end else if (clr_req) begin
            m_q    = '0;
            m_cnt  = 0;
            m_busy = 1'b1;
        end else if (req0 || req1) begin
            if (req0 && req1) w = m_fav;
            else              w = req1 ? 1 : 0;
            m_g0         = (w == 0);
            m_g1         = (w == 1);
            m_pend       = (w == 1) ? data1 : data0;
            m_pend_valid = 1'b1;
            m_fav        = 1 - w;
            m_cnt        = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_busy       = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("gnt0",   32'(gnt0),        32'(m_g0));
        chk("gnt1",   32'(gnt1),        32'(m_g1));
        chk("mutex",  32'(gnt0 & gnt1), 32'(0));
        chk("qout",   32'(qout),        32'(m_q));
        chk("busy",   32'(busy),        32'(m_busy));
        chk("wr_cnt", 32'(wr_cnt),      32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges; effects checked before any edge.
    task automatic pulse_reset();
        #1;
        clr = 1'b1;
        #1;
        model_reset();
        chk("rst_qout", 32'(qout),   32'(0));
        chk("rst_gnt",  32'({gnt1, gnt0}), 32'(0));
        chk("rst_busy", 32'(busy),   32'(0));
        chk("rst_cnt",  32'(wr_cnt), 32'(0));
        clr = 1'b0;
    endtask

    initial begin
        clr     = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        data0   = '0;
        data1   = '0;
        clr_req = 1'b0;
        model_reset();

        // Power-on reset held across two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        clr = 1'b0;

        // Single write from requester 0.
        req0  = 1'b1;
        data0 = 4'h5;
        tick();
        chk("single_gnt0", 32'(gnt0), 32'(1));
        req0 = 1'b0;
        tick();
        chk("single_qout", 32'(qout), 32'(5));
        chk("single_cnt",  32'(wr_cnt), 32'(1));

        // Contention from a fresh reset: order 0,1,0,1, values 3,C alternating.
        pulse_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 4'h3;
        data1 = 4'hC;
        for (int i = 0; i < 8; i++) tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Clear priority with qout=5 and a pending req1.
        pulse_reset();
        req0  = 1'b1;
        data0 = 4'h5;
        tick();
        req0 = 1'b0;
        tick();
        chk("pre_clear_qout", 32'(qout), 32'(5));
        clr_req = 1'b1;
        req1    = 1'b1;
        data1   = 4'h9;
        tick();
        chk("clear_qout", 32'(qout), 32'(0));
        chk("clear_cnt",  32'(wr_cnt), 32'(0));
        clr_req = 1'b0;
        tick();
        tick();
        chk("after_clear_gnt1", 32'(gnt1), 32'(1));
        req1 = 1'b0;
        tick();
        chk("after_clear_qout", 32'(qout), 32'(9));

        // Saturation: 260 grants with req0 held.
        pulse_reset();
        req0  = 1'b1;
        data0 = 4'h7;
        for (int i = 0; i < 520; i++) tick();
        req0 = 1'b0;
        tick();
        chk("sat_cnt", 32'(wr_cnt), 32'(255));

        // Asynchronous reset in the middle of LOAD: no write completes.
        req1  = 1'b1;
        data1 = 4'hA;
        tick();
        req1 = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'(1));
        pulse_reset();
        tick();
        chk("abort_qout", 32'(qout), 32'(0));

        // Hold: write a value, then ten idle cycles.
        req1  = 1'b1;
        data1 = 4'hE;
        tick();
        req1 = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("hold_qout", 32'(qout), 32'(14));

        // Randomized traffic following the req/gnt handshake.
        for (int i = 0; i < 400; i++) begin
            if (m_g0) req0 = 1'b0;
            if (m_g1) req1 = 1'b0;
            if (!req0 && ($urandom_range(0, 2) == 0)) begin
                req0  = 1'b1;
                data0 = WIDTH'($urandom);
            end
            if (!req1 && ($urandom_range(0, 2) == 0)) begin
                req1  = 1'b1;
                data1 = WIDTH'($urandom);
            end
            if (clr_req) clr_req = 1'b0;
            else         clr_req = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
